// File: rtl/mac_drain_if.sv
// mac_drain_if: start/capture/emit handshake bundle between a PE column drain and its neighbours.
interface mac_drain_if #(parameter int DATA_WIDTH = 8);
  logic                           start;
  logic signed [2*DATA_WIDTH-1:0] mac_in;
  logic                           write_out_en;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [DATA_WIDTH-1:0]   out_data;
  logic signed [2*DATA_WIDTH-1:0] out_raw;
  logic                           busy;
  logic                           done;
  modport master (output start, mac_in, out_ready,
                  input  write_out_en, out_valid, out_data, out_raw, busy, done);
  modport slave  (input  start, mac_in, out_ready,
                  output write_out_en, out_valid, out_data, out_raw, busy, done);
endinterface

// File: rtl/mac_drain.sv
// mac_drain: shifts a PE column's mac results out of the chain into a buffer, then emits them
// tail-first over a valid/ready port with signed saturation to DATA_WIDTH.
module mac_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_ROW    = 4
) (
  input logic       clk,
  input logic       rst_n,
  mac_drain_if.slave bus
);
  localparam int MW = 2*DATA_WIDTH;
  localparam int CW = $clog2(NUM_ROW);
  localparam logic [CW-1:0] LAST = CW'(NUM_ROW-1);
  localparam logic signed [MW-1:0] SAT_MAX = MW'((1 << (DATA_WIDTH-1)) - 1);
  localparam logic signed [MW-1:0] SAT_MIN = ~SAT_MAX;
  typedef enum logic [1:0] {IDLE, CAPTURE, EMIT} state_t;
  state_t state, state_d;
  logic [CW-1:0] cnt, rd;
  logic signed [MW-1:0] buf_q [NUM_ROW];
  logic signed [MW-1:0] raw;
  logic xfer, last_xfer, done_q;
  always_comb begin
    xfer             = state == EMIT && bus.out_ready;
    last_xfer        = xfer && rd == LAST;
    raw              = buf_q[rd];
    bus.write_out_en = state == CAPTURE && cnt < LAST;
    bus.out_valid    = state == EMIT;
    bus.busy         = state != IDLE;
    bus.done         = done_q;
    bus.out_raw      = raw;
    bus.out_data     = raw > SAT_MAX ? DATA_WIDTH'(SAT_MAX) :
                       raw < SAT_MIN ? DATA_WIDTH'(SAT_MIN) : raw[DATA_WIDTH-1:0];
    state_d = state == IDLE    ? (bus.start  ? CAPTURE : IDLE) :
              state == CAPTURE ? (cnt == LAST ? EMIT : CAPTURE) :
              state == EMIT    ? (last_xfer  ? IDLE : EMIT) : IDLE;
  end
  // The chain cannot be held, so capture runs every cycle regardless of out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      rd     <= '0;
      done_q <= 1'b0;
      for (int i = 0; i < NUM_ROW; i++) buf_q[i] <= '0;
    end else begin
      state  <= state_d;
      cnt    <= (state == CAPTURE && cnt != LAST) ? cnt + 1'b1 : '0;
      rd     <= (state != EMIT || last_xfer) ? '0 : rd + CW'(xfer);
      done_q <= last_xfer;
      if (state == CAPTURE) buf_q[cnt] <= bus.mac_in;
    end
  end
endmodule

// File: tb/tb_mac_drain.sv
// tb_mac_drain: directed checks of mac_drain against a 4-PE shift-chain model.
module tb_mac_drain;
  logic clk, rst_n, load;
  logic signed [15:0] chain [4];
  logic signed [15:0] load_vals [4];
  int checks = 0;
  int errors = 0;
  mac_drain_if #(.DATA_WIDTH(8)) bus ();
  mac_drain #(.DATA_WIDTH(8), .NUM_ROW(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // Column model: row 3 is the tail; a shift moves every result one row toward it.
  always @(posedge clk) begin
    if (load) chain <= load_vals;
    else if (bus.write_out_en) begin
      for (int i = 3; i > 0; i--) chain[i] <= chain[i-1];
      chain[0] <= '0;
    end
  end
  assign bus.mac_in = chain[3];
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic int sat(input int v);
    return v > 127 ? 127 : (v < -128 ? -128 : v);
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic begin_drain(input int rows [4]);
    for (int i = 0; i < 4; i++) load_vals[i] = 16'(rows[i]);
    load = 1'b1;
    bus.start = 1'b1;
    tick;
    load = 1'b0;
    bus.start = 1'b0;
  endtask
  task automatic drain(input int rows [4], input bit poke);
    int ex;
    bus.out_ready = 1'b1;
    begin_drain(rows);
    for (int c = 0; c < 4; c++) begin
      check("cap_busy", int'(bus.busy), 1);
      check("cap_wen", int'(bus.write_out_en), int'(c < 3));
      check("cap_valid", int'(bus.out_valid), 0);
      if (poke && c == 1) bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      ex = rows[3-k];
      check("emit_valid", int'(bus.out_valid), 1);
      check("emit_raw", int'($signed(bus.out_raw)), ex);
      check("emit_data", int'($signed(bus.out_data)), sat(ex));
      check("emit_wen", int'(bus.write_out_en), 0);
      check("emit_done", int'(bus.done), 0);
      if (poke && k == 1) bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
    end
    check("done_pulse", int'(bus.done), 1);
    check("done_idle", int'(bus.busy), 0);
  endtask
  initial begin
    int pat [7] = '{0, 0, 1, 0, 1, 1, 1};
    int bp [4]  = '{11, 22, 33, 44};
    int idx;
    rst_n = 1'b0;
    load = 1'b0;
    bus.start = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) load_vals[i] = '0;
    tick;
    tick;
    check("rst_busy", int'(bus.busy), 0);
    check("rst_valid", int'(bus.out_valid), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_wen", int'(bus.write_out_en), 0);
    rst_n = 1'b1;
    tick;
    tick;
    check("post_rst_idle", int'(bus.busy), 0);
    drain('{10, 20, 30, 40}, 1'b0);
    tick;
    check("basic_done_drop", int'(bus.done), 0);
    drain('{-128, 127, -200, 300}, 1'b0);
    tick;
    drain('{5, 6, 7, 8}, 1'b1);
    tick;
    check("ign_done_drop", int'(bus.done), 0);
    check("ign_no_restart", int'(bus.busy), 0);
    tick;
    check("ign_single_done", int'(bus.done), 0);
    drain('{10, 20, 30, 40}, 1'b0);
    drain('{1, 2, 3, 4}, 1'b0);
    tick;
    check("b2b_idle", int'(bus.busy), 0);
    // Backpressure: stall pattern during EMIT.
    bus.out_ready = 1'b1;
    begin_drain(bp);
    repeat (4) tick;
    idx = 0;
    for (int i = 0; i < 7; i++) begin
      bus.out_ready = pat[i][0];
      #1;
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_raw", int'($signed(bus.out_raw)), bp[3-idx]);
      check("bp_wen", int'(bus.write_out_en), 0);
      check("bp_no_early_done", int'(bus.done), 0);
      tick;
      if (pat[i] == 1) idx++;
    end
    check("bp_transfers", idx, 4);
    check("bp_done", int'(bus.done), 1);
    check("bp_idle", int'(bus.busy), 0);
    bus.out_ready = 1'b1;
    tick;
    // Reset while EMIT presents word 2.
    begin_drain('{50, 60, 70, 80});
    repeat (4) tick;
    tick;
    tick;
    check("rm_word2", int'($signed(bus.out_raw)), 60);
    #2 rst_n = 1'b0;
    #1;
    check("rm_valid", int'(bus.out_valid), 0);
    check("rm_busy", int'(bus.busy), 0);
    check("rm_raw", int'($signed(bus.out_raw)), 0);
    check("rm_wen", int'(bus.write_out_en), 0);
    check("rm_done", int'(bus.done), 0);
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("rm_no_done", int'(bus.done), 0);
      check("rm_stay_idle", int'(bus.busy), 0);
      tick;
    end
    drain('{7, -9, 250, -300}, 1'b0);
    tick;
    check("final_done_drop", int'(bus.done), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
